inst_ram_boot_loader: RTL and testbench
=======================================

Name: inst_ram_boot_loader

Overview:
- Synthesisable successor to the hand-scripted instruction-RAM preload sequence.
- Accepts a stream of program words over a valid/ready handshake and writes each word to consecutive word addresses starting at PC_INITIAL.
- Holds the CPU in reset/debug during loading, waits a programmable settle time, then releases the CPU.
- Sits between a program source (UART/ROM/bench) and the CPU's `inst_ram_write_*`, `reset` and `debug` inputs.

Parameters:
- PC_INITIAL, 32'hbfc00000, first write address and the address restored on release.
- DATA_W, 32, instruction word width.
- ADDR_W, 32, write address width.
- MAX_WORDS, 1024, maximum number of words per load; a 1025th word is an overflow.
- GAP_CYCLES, 1, idle cycles with write enable low between writes; 0 means back-to-back writes.
- HOLD_CYCLES, 70, cycles to hold reset after the last write before release.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; honoured only in IDLE or RUN.
- src_valid  in  1  source word valid.
- src_data  in  DATA_W  source instruction word.
- src_last  in  1  marks the final word of the program.
- src_ready  out  1  loader can accept a word.
- debug  out  1  CPU debug hold.
- cpu_reset  out  1  CPU reset hold (drives CPU `reset`).
- inst_ram_write_enable  out  1  RAM write strobe.
- inst_ram_write_data  out  DATA_W  RAM write data.
- inst_ram_write_address  out  ADDR_W  RAM write address.
- loaded_words  out  clog2(MAX_WORDS+1)  number of words written in the current load.
- done  out  1  CPU released.
- overflow  out  1  sticky: a load exceeded MAX_WORDS.
- checksum  out  32  see Optional Feature.

Behaviour:
- Reset values (reset high at a clk edge):
  - state = IDLE; debug = 1; cpu_reset = 1; write_enable = 0; write_data = 0; write_address = PC_INITIAL.
  - src_ready = 0; loaded_words = 0; done = 0; overflow = 0; checksum = 0.
  - Reset mid-load aborts the load immediately; no further writes occur.
- States: IDLE, LOAD, WRITE, GAP, HOLD, RUN.
- IDLE:
  - All CPU holds asserted.
  - start = 1 → LOAD; clears loaded_words, overflow and checksum.
- LOAD:
  - src_ready = 1.
  - On src_valid & src_ready: latch data, address = PC_INITIAL + 4*loaded_words (mod 2^ADDR_W), and the src_last flag → WRITE.
  - If loaded_words == MAX_WORDS when a word is accepted: set overflow, do not write, go to HOLD.
- WRITE:
  - write_enable = 1 for exactly one cycle, in the cycle after the handshake.
  - Data and address are stable while the strobe is high.
  - loaded_words increments.
  - Next state: latched last → HOLD; GAP_CYCLES == 0 → LOAD; otherwise → GAP.
- GAP:
  - write_enable = 0 and src_ready = 0 for GAP_CYCLES cycles, then → LOAD.
  - Data and address hold their last values.
- HOLD:
  - debug = cpu_reset = 1 for HOLD_CYCLES cycles (HOLD_CYCLES == 0 means one cycle), then → RUN.
- RUN:
  - debug = 0; cpu_reset = 0; done = 1.
  - write_address = PC_INITIAL; write_data = 0.
  - start = 1 → LOAD: cpu_reset, debug and holds reasserted in the same edge; done cleared.
- Ignored events:
  - start outside IDLE/RUN is ignored.
  - src_valid outside LOAD is not accepted (src_ready = 0).
- Latency: handshake at edge t → strobe high during cycle t+1. Maximum throughput is one word per (2 + GAP_CYCLES) cycles.
- Write enable is never high in IDLE, HOLD or RUN.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- With the macro defined: checksum accumulates the 32-bit modular sum of every written word (zero-extended or truncated to 32 bits), updated in the WRITE cycle and frozen in HOLD/RUN.
- Without the macro: checksum is tied to 0 and no accumulator is built.

Decomposition:
- Shared package:
  - state enum boot_state_t {IDLE, LOAD, WRITE, GAP, HOLD, RUN};
  - PC_INITIAL default constant;
  - instruction word width constant.
- Sub-module: one reusable down-counter `cycle_delay_counter` (load value, done flag), used by both GAP and HOLD.

Test Plan:
- Load 3 words 0x200F0AF4, 0x20180004, 0x01F85020 (last on the third), GAP = 1 → write addresses 0xbfc00000/04/08 each with a one-cycle strobe; loaded_words = 3; cpu_reset falls exactly HOLD_CYCLES + 1 cycles after the third strobe.
- GAP_CYCLES = 0 with src_valid held high → strobes every 2 cycles; src_ready low in WRITE cycles.
- MAX_WORDS = 2, send 3 words → 2 writes, overflow = 1, third word not written, CPU still released.
- Assert reset during the second write's GAP → all outputs return to reset values next cycle; no further strobe.
- From RUN, pulse start and reload the word 0x21290001 → cpu_reset reasserted the next cycle; write at 0xbfc00000; released again.
- With BOOT_LOADER_CHECKSUM_EN, words 0x8F0A0004 + 0xAF0B0004 → checksum = 0x3E150008; without the macro → checksum = 0.

Source files
------------

// File: rtl/inst_ram_boot_loader_pkg.sv
// Shared types and defaults for the instruction-RAM boot loader.
package inst_ram_boot_loader_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, GAP, HOLD, RUN} boot_state_t;
    localparam logic [31:0] PC_INITIAL_DEFAULT = 32'hbfc00000;
    localparam int unsigned INST_W = 32;
endpackage

// File: rtl/inst_ram_boot_loader_if.sv
// Program-word stream handshake between a program source and the boot loader.
interface inst_ram_boot_loader_if
    import inst_ram_boot_loader_pkg::*;
#(
    parameter int unsigned DATA_W = INST_W
);
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_last;
    logic              src_ready;

    modport master (output src_valid, src_data, src_last, input src_ready);
    modport slave  (input src_valid, src_data, src_last, output src_ready);
endinterface

// File: rtl/inst_ram_boot_loader_delay.sv
// Reloadable down-counter; done is high once the count has reached zero.
module cycle_delay_counter
    import inst_ram_boot_loader_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);
endmodule

// File: rtl/inst_ram_boot_loader.sv
// Streams program words into instruction RAM while holding the CPU, then releases it.
// Optional running checksum of written words: define BOOT_LOADER_CHECKSUM_EN.
module inst_ram_boot_loader
    import inst_ram_boot_loader_pkg::*;
#(
    parameter int unsigned        DATA_W      = INST_W,
    parameter int unsigned        ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]  PC_INITIAL  = ADDR_W'(PC_INITIAL_DEFAULT),
    parameter int unsigned        MAX_WORDS   = 1024,
    parameter int unsigned        GAP_CYCLES  = 1,
    parameter int unsigned        HOLD_CYCLES = 70,
    localparam int unsigned       LW_W        = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    inst_ram_boot_loader_if.slave src,
    output logic                  debug,
    output logic                  cpu_reset,
    output logic                  inst_ram_write_enable,
    output logic [DATA_W-1:0]     inst_ram_write_data,
    output logic [ADDR_W-1:0]     inst_ram_write_address,
    output logic [LW_W-1:0]       loaded_words,
    output logic                  done,
    output logic                  overflow,
    output logic [31:0]           checksum
);
    // Counter reload values: a delay of N cycles loads N-1; HOLD of 0 still lasts one cycle.
    localparam logic [31:0]     GAP_LOAD  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
    localparam logic [31:0]     HOLD_LOAD = (HOLD_CYCLES == 0) ? 32'd0 : 32'(HOLD_CYCLES - 1);
    localparam logic [LW_W-1:0] MAX_COUNT = LW_W'(MAX_WORDS);

    boot_state_t       state, next_state;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              last_q;
    logic              accept, full, restart;
    logic              delay_load, delay_done;
    logic [31:0]       delay_value;

    assign accept  = src.src_valid && src.src_ready;
    assign full    = (loaded_words == MAX_COUNT);
    assign restart = start && (state == IDLE || state == RUN);

    cycle_delay_counter #(.W(32)) u_delay (
        .clk        (clk),
        .reset      (reset),
        .load       (delay_load),
        .load_value (delay_value),
        .done       (delay_done)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (accept) next_state = full ? HOLD : WRITE;
            WRITE: begin
                if (last_q)
                    next_state = HOLD;
                else if (GAP_CYCLES == 0)
                    next_state = LOAD;
                else
                    next_state = GAP;
            end
            GAP:     if (delay_done) next_state = LOAD;
            HOLD:    if (delay_done) next_state = RUN;
            RUN:     if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        src.src_ready         = (state == LOAD);
        inst_ram_write_enable = (state == WRITE);
        debug                 = (state != RUN);
        cpu_reset             = (state != RUN);
        done                  = (state == RUN);
        delay_load            = (next_state != state) && (next_state == GAP || next_state == HOLD);
        delay_value           = (next_state == GAP) ? GAP_LOAD : HOLD_LOAD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= '0;
            addr_q       <= PC_INITIAL;
            last_q       <= 1'b0;
            loaded_words <= '0;
            overflow     <= 1'b0;
        end else begin
            if (restart) begin
                loaded_words <= '0;
                overflow     <= 1'b0;
            end
            if (state == LOAD && accept) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    data_q <= src.src_data;
                    addr_q <= PC_INITIAL + (ADDR_W'(loaded_words) << 2);
                    last_q <= src.src_last;
                end
            end
            if (state == WRITE)
                loaded_words <= loaded_words + LW_W'(1);
            if (state == HOLD && next_state == RUN) begin
                data_q <= '0;
                addr_q <= PC_INITIAL;
            end
        end
    end

    assign inst_ram_write_data    = data_q;
    assign inst_ram_write_address = addr_q;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || restart)
            sum_q <= '0;
        else if (state == WRITE)
            sum_q <= sum_q + 32'(data_q);
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_inst_ram_boot_loader.sv
// Directed bench for inst_ram_boot_loader: three instances cover GAP=1, GAP=0 and overflow.
module tb_inst_ram_boot_loader;
    localparam logic [31:0] PC = 32'hbfc00000;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam logic [31:0] SUM_A = 32'h421F5B18;
    localparam logic [31:0] SUM_B = 32'h3E150008;
    localparam logic [31:0] SUM_C = 32'h00000033;
`else
    localparam logic [31:0] SUM_A = 32'h0;
    localparam logic [31:0] SUM_B = 32'h0;
    localparam logic [31:0] SUM_C = 32'h0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b, start_c;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] words [3];

    inst_ram_boot_loader_if #(.DATA_W(32)) if_a ();
    inst_ram_boot_loader_if #(.DATA_W(32)) if_b ();
    inst_ram_boot_loader_if #(.DATA_W(32)) if_c ();

    logic        debug_a, cpu_reset_a, we_a, done_a, overflow_a;
    logic [31:0] wdata_a, waddr_a, checksum_a;
    logic [10:0] loaded_a;
    logic        debug_b, cpu_reset_b, we_b, done_b, overflow_b;
    logic [31:0] wdata_b, waddr_b, checksum_b;
    logic [10:0] loaded_b;
    logic        debug_c, cpu_reset_c, we_c, done_c, overflow_c;
    logic [31:0] wdata_c, waddr_c, checksum_c;
    logic [1:0]  loaded_c;

    inst_ram_boot_loader dut_a (
        .clk(clk), .reset(reset), .start(start_a), .src(if_a),
        .debug(debug_a), .cpu_reset(cpu_reset_a), .inst_ram_write_enable(we_a),
        .inst_ram_write_data(wdata_a), .inst_ram_write_address(waddr_a),
        .loaded_words(loaded_a), .done(done_a), .overflow(overflow_a), .checksum(checksum_a)
    );

    inst_ram_boot_loader #(.GAP_CYCLES(0), .HOLD_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .src(if_b),
        .debug(debug_b), .cpu_reset(cpu_reset_b), .inst_ram_write_enable(we_b),
        .inst_ram_write_data(wdata_b), .inst_ram_write_address(waddr_b),
        .loaded_words(loaded_b), .done(done_b), .overflow(overflow_b), .checksum(checksum_b)
    );

    inst_ram_boot_loader #(.MAX_WORDS(2), .HOLD_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .src(if_c),
        .debug(debug_c), .cpu_reset(cpu_reset_c), .inst_ram_write_enable(we_c),
        .inst_ram_write_data(wdata_c), .inst_ram_write_address(waddr_c),
        .loaded_words(loaded_c), .done(done_c), .overflow(overflow_c), .checksum(checksum_c)
    );

    // Presents one word on the selected source and returns at the negedge after the handshake.
    task automatic drive_word(input int sel, input logic [31:0] d, input logic l, output bit ok);
        ok = 1'b0;
        case (sel)
            0:       begin if_a.src_valid = 1'b1; if_a.src_data = d; if_a.src_last = l; end
            1:       begin if_b.src_valid = 1'b1; if_b.src_data = d; if_b.src_last = l; end
            default: begin if_c.src_valid = 1'b1; if_c.src_data = d; if_c.src_last = l; end
        endcase
        for (int i = 0; i < 20; i++) begin
            if ((sel == 0 && if_a.src_ready) || (sel == 1 && if_b.src_ready) ||
                (sel == 2 && if_c.src_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if_a.src_valid = 1'b0;
        if_b.src_valid = 1'b0;
        if_c.src_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        if_a.src_valid = 1'b0; if_a.src_data = '0; if_a.src_last = 1'b0;
        if_b.src_valid = 1'b0; if_b.src_data = '0; if_b.src_last = 1'b0;
        if_c.src_valid = 1'b0; if_c.src_data = '0; if_c.src_last = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (debug_a !== 1'b1) begin errors++; $display("FAIL rst_debug: got %0b want 1", debug_a); end
        checks++; if (cpu_reset_a !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %0b want 1", cpu_reset_a); end
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", we_a); end
        checks++; if (wdata_a !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", wdata_a); end
        checks++; if (waddr_a !== PC) begin errors++; $display("FAIL rst_waddr: got %h want %h", waddr_a, PC); end
        checks++; if (if_a.src_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", if_a.src_ready); end
        checks++; if (loaded_a !== 11'd0) begin errors++; $display("FAIL rst_loaded: got %0d want 0", loaded_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", done_a); end
        checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b want 0", overflow_a); end
        checks++; if (checksum_a !== 32'h0) begin errors++; $display("FAIL rst_checksum: got %h want 0", checksum_a); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (if_a.src_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %0b want 0", if_a.src_ready); end
    endtask

    task automatic test_load_three();
        bit ok, saw_we;
        int n;
        words[0] = 32'h200F0AF4; words[1] = 32'h20180004; words[2] = 32'h01F85020;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        checks++; if (if_a.src_ready !== 1'b1) begin errors++; $display("FAIL a_load_ready: got %0b want 1", if_a.src_ready); end
        for (int k = 0; k < 3; k++) begin
            drive_word(0, words[k], k == 2, ok);
            checks++; if (!ok) begin errors++; $display("FAIL a_accept%0d: src_ready never high", k); end
            checks++; if (we_a !== 1'b1) begin errors++; $display("FAIL a_strobe%0d: got %0b want 1", k, we_a); end
            checks++; if (wdata_a !== words[k]) begin errors++; $display("FAIL a_wdata%0d: got %h want %h", k, wdata_a, words[k]); end
            checks++; if (waddr_a !== PC + 32'(4 * k)) begin errors++; $display("FAIL a_waddr%0d: got %h want %h", k, waddr_a, PC + 32'(4 * k)); end
            if (k < 2) begin
                @(negedge clk);
                checks++; if (we_a !== 1'b0 || if_a.src_ready !== 1'b0) begin errors++; $display("FAIL a_gap%0d: we=%0b ready=%0b want 0 0", k, we_a, if_a.src_ready); end
                checks++; if (wdata_a !== words[k]) begin errors++; $display("FAIL a_gap_hold%0d: got %h want %h", k, wdata_a, words[k]); end
            end
        end
        n = 0; saw_we = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (we_a) saw_we = 1'b1;
            if (!cpu_reset_a) begin n = i; break; end
        end
        checks++; if (n != 71) begin errors++; $display("FAIL a_release: cpu_reset fell after %0d cycles want 71", n); end
        checks++; if (saw_we) begin errors++; $display("FAIL a_hold_we: strobe seen in HOLD"); end
        checks++; if (done_a !== 1'b1 || debug_a !== 1'b0) begin errors++; $display("FAIL a_run: done=%0b debug=%0b want 1 0", done_a, debug_a); end
        checks++; if (loaded_a !== 11'd3) begin errors++; $display("FAIL a_loaded: got %0d want 3", loaded_a); end
        checks++; if (waddr_a !== PC || wdata_a !== 32'h0) begin errors++; $display("FAIL a_run_bus: addr=%h data=%h want %h 0", waddr_a, wdata_a, PC); end
        checks++; if (checksum_a !== SUM_A) begin errors++; $display("FAIL a_checksum: got %h want %h", checksum_a, SUM_A); end
    endtask

    task automatic test_back_to_back();
        int n;
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        if_b.src_valid = 1'b1; if_b.src_data = words[0]; if_b.src_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (if_b.src_ready !== 1'b1) begin errors++; $display("FAIL b_ready%0d: got %0b want 1", k, if_b.src_ready); end
            @(negedge clk);
            checks++; if (we_b !== 1'b1 || if_b.src_ready !== 1'b0) begin errors++; $display("FAIL b_write%0d: we=%0b ready=%0b want 1 0", k, we_b, if_b.src_ready); end
            checks++; if (wdata_b !== words[k] || waddr_b !== PC + 32'(4 * k)) begin errors++; $display("FAIL b_bus%0d: data=%h addr=%h want %h %h", k, wdata_b, waddr_b, words[k], PC + 32'(4 * k)); end
            if (k < 2) begin
                if_b.src_data = words[k + 1];
                if_b.src_last = (k == 1);
                @(negedge clk);
                checks++; if (we_b !== 1'b0) begin errors++; $display("FAIL b_we_low%0d: got %0b want 0", k, we_b); end
            end
        end
        if_b.src_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!cpu_reset_b) begin n = i; break; end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL b_release: cpu_reset fell after %0d cycles want 3", n); end
        checks++; if (loaded_b !== 11'd3 || done_b !== 1'b1 || debug_b !== 1'b0) begin errors++; $display("FAIL b_run: loaded=%0d done=%0b debug=%0b want 3 1 0", loaded_b, done_b, debug_b); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [31:0] w [3];
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
        start_c = 1'b1; @(negedge clk); start_c = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_word(2, w[k], 1'b0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL c_accept%0d: src_ready never high", k); end
            checks++; if (we_c !== 1'b1 || wdata_c !== w[k] || waddr_c !== PC + 32'(4 * k)) begin errors++; $display("FAIL c_write%0d: we=%0b data=%h addr=%h", k, we_c, wdata_c, waddr_c); end
        end
        drive_word(2, w[2], 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL c_accept2: src_ready never high"); end
        checks++; if (we_c !== 1'b0 || overflow_c !== 1'b1) begin errors++; $display("FAIL c_overflow: we=%0b overflow=%0b want 0 1", we_c, overflow_c); end
        checks++; if (loaded_c !== 2'd2 || cpu_reset_c !== 1'b1 || debug_c !== 1'b1) begin errors++; $display("FAIL c_hold: loaded=%0d cpu_reset=%0b debug=%0b want 2 1 1", loaded_c, cpu_reset_c, debug_c); end
        @(negedge clk);
        checks++; if (cpu_reset_c !== 1'b0 || done_c !== 1'b1 || we_c !== 1'b0) begin errors++; $display("FAIL c_release: cpu_reset=%0b done=%0b we=%0b want 0 1 0", cpu_reset_c, done_c, we_c); end
        checks++; if (checksum_c !== SUM_C) begin errors++; $display("FAIL c_checksum: got %h want %h", checksum_c, SUM_C); end
    endtask

    task automatic test_restart();
        bit ok;
        int n;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        checks++; if (cpu_reset_a !== 1'b1 || debug_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL r_hold: cpu_reset=%0b debug=%0b done=%0b want 1 1 0", cpu_reset_a, debug_a, done_a); end
        checks++; if (loaded_a !== 11'd0 || checksum_a !== 32'h0) begin errors++; $display("FAIL r_clear: loaded=%0d checksum=%h want 0 0", loaded_a, checksum_a); end
        drive_word(0, 32'h21290001, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL r_accept: src_ready never high"); end
        checks++; if (we_a !== 1'b1 || wdata_a !== 32'h21290001 || waddr_a !== PC) begin errors++; $display("FAIL r_write: we=%0b data=%h addr=%h", we_a, wdata_a, waddr_a); end
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start_a = (i == 5);
            if (!cpu_reset_a) begin n = i; break; end
        end
        start_a = 1'b0;
        checks++; if (n != 71) begin errors++; $display("FAIL r_release: cpu_reset fell after %0d cycles want 71", n); end
        checks++; if (loaded_a !== 11'd1 || done_a !== 1'b1) begin errors++; $display("FAIL r_run: loaded=%0d done=%0b want 1 1", loaded_a, done_a); end
    endtask

    task automatic test_checksum();
        bit ok, seen;
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        drive_word(1, 32'h8F0A0004, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL k_accept0: src_ready never high"); end
        drive_word(1, 32'hAF0B0004, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL k_accept1: src_ready never high"); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_b) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL k_done: done never high"); end
        checks++; if (checksum_b !== SUM_B) begin errors++; $display("FAIL k_checksum: got %h want %h", checksum_b, SUM_B); end
        checks++; if (loaded_b !== 11'd2 || overflow_b !== 1'b0) begin errors++; $display("FAIL k_count: loaded=%0d overflow=%0b want 2 0", loaded_b, overflow_b); end
    endtask

    task automatic test_reset_mid_load();
        bit ok, saw;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        drive_word(0, words[0], 1'b0, ok);
        drive_word(0, words[1], 1'b0, ok);
        checks++; if (!ok || we_a !== 1'b1) begin errors++; $display("FAIL m_second_write: ok=%0b we=%0b want 1 1", ok, we_a); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (we_a !== 1'b0 || debug_a !== 1'b1 || cpu_reset_a !== 1'b1) begin errors++; $display("FAIL m_holds: we=%0b debug=%0b cpu_reset=%0b want 0 1 1", we_a, debug_a, cpu_reset_a); end
        checks++; if (wdata_a !== 32'h0 || waddr_a !== PC || loaded_a !== 11'd0) begin errors++; $display("FAIL m_bus: data=%h addr=%h loaded=%0d want 0 %h 0", wdata_a, waddr_a, loaded_a, PC); end
        if_a.src_valid = 1'b1; if_a.src_data = words[2]; if_a.src_last = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (we_a || if_a.src_ready) saw = 1'b1;
        end
        if_a.src_valid = 1'b0;
        checks++; if (saw) begin errors++; $display("FAIL m_no_write: strobe or ready seen after reset"); end
    endtask

    initial begin
        test_reset();
        test_load_three();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_checksum();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
